// File: rtl/dat_mem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory: core (C) first, loader (L) with burst lock.
// Define DMEM_ARB_STARVE_EN to enable the loader starvation guard (STARVE_MAX).
module dat_mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_wr,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    arb_state
);
    // Handshake: a requester holds req/wr/addr/wdata until it sees gnt in the same cycle;
    // dropping req before gnt cancels. Read data follows with rvalid one cycle after gnt.

    typedef enum logic [1:0] {IDLE = 2'd0, C_OWN = 2'd1, L_OWN = 2'd2, L_LOCK = 2'd3} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          starve_hit;
    logic          l_pick;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (l_gnt || !l_req)
            starve_cnt <= '0;
        else if (c_gnt && starve_cnt != 4'(STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are combinational and masked while reset is high so nothing reaches the memory.
    always_comb begin
        l_pick    = l_req && ((state == L_LOCK) || starve_hit || !c_req);
        l_gnt     = !reset && l_pick;
        c_gnt     = !reset && c_req && !l_pick;
        mem_wr_en = (c_gnt && c_wr) || (l_gnt && l_wr);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == L_LOCK && !(l_req && l_lock))
            state_nxt = IDLE;
        else if (l_gnt && l_lock)
            state_nxt = L_LOCK;
        else if (l_gnt)
            state_nxt = L_OWN;
        else if (c_gnt)
            state_nxt = C_OWN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign arb_state = state;

    // Address/data hold the last granted values so idle cycles never present new bus activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (c_gnt || l_gnt) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rvalid <= 1'b0;
            l_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt && !c_wr;
            l_rvalid <= l_gnt && !l_wr;
            if (c_gnt && !c_wr)
                c_rdata <= mem_rdata;
            if (l_gnt && !l_wr)
                l_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Bench for dat_mem_arbiter: behavioural memory, cycle-by-cycle reference model, directed scenarios.
module tb_dat_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SMAX = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk, reset;
    logic c_req, c_wr, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic l_req, l_wr, l_lock, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0] arb_state;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    dat_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_wr(l_wr), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_state(arb_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at posedge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: who must own the memory this cycle, from the arbitration rules
    int            l_wait;      // consecutive cycles L was passed over for C
    bit            burst;       // L won last cycle with lock held
    bit            exp_crv, exp_lrv, addr_known;
    logic [DW-1:0] exp_crd, exp_lrd;
    logic [AW-1:0] last_addr;

    always @(negedge clk) begin
        bit ec, el;
        if (reset) begin
            check("rst_c_gnt", c_gnt, 0);
            check("rst_l_gnt", l_gnt, 0);
            check("rst_wr_en", mem_wr_en, 0);
            check("rst_c_rvalid", c_rvalid, 0);
            check("rst_l_rvalid", l_rvalid, 0);
            check("rst_c_rdata", c_rdata, 0);
            check("rst_l_rdata", l_rdata, 0);
            l_wait = 0; burst = 0; exp_crv = 0; exp_lrv = 0;
            exp_crd = '0; exp_lrd = '0; addr_known = 0;
        end else begin
            ec = 0; el = 0;
            if (l_req && burst) el = 1;
            else if (l_req && STARVE_ON && l_wait >= SMAX) el = 1;
            else if (c_req) ec = 1;
            else if (l_req) el = 1;
            check("c_gnt", c_gnt, ec);
            check("l_gnt", l_gnt, el);
            check("wr_en", mem_wr_en, (ec && c_wr) || (el && l_wr));
            check("c_rvalid", c_rvalid, exp_crv);
            check("c_rdata", c_rdata, exp_crd);
            check("l_rvalid", l_rvalid, exp_lrv);
            check("l_rdata", l_rdata, exp_lrd);
            if (ec) check("c_addr_out", mem_addr, c_addr);
            if (el) check("l_addr_out", mem_addr, l_addr);
            if (ec && c_wr) check("c_wdata_out", mem_wdata, c_wdata);
            if (el && l_wr) check("l_wdata_out", mem_wdata, l_wdata);
            if (!ec && !el && addr_known) check("addr_hold", mem_addr, last_addr);
            exp_crv = ec && !c_wr;
            exp_lrv = el && !l_wr;
            if (exp_crv) exp_crd = ref_mem[c_addr];
            if (exp_lrv) exp_lrd = ref_mem[l_addr];
            if (ec) begin
                last_addr = c_addr; addr_known = 1;
                if (c_wr) ref_mem[c_addr] = c_wdata;
            end
            if (el) begin
                last_addr = l_addr; addr_known = 1;
                if (l_wr) ref_mem[l_addr] = l_wdata;
            end
            if (el || !l_req) l_wait = 0;
            else if (ec) l_wait = (l_wait + 1 > SMAX) ? SMAX : l_wait + 1;
            burst = el && l_lock;
        end
    end

    // Driver tasks
    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_c(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_req = req; c_wr = wr; c_addr = a; c_wdata = d;
    endtask

    task automatic drv_l(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic lk);
        l_req = req; l_wr = wr; l_addr = a; l_wdata = d; l_lock = lk;
    endtask

    logic [8:0] c_pat, l_pat, exp_c_pat, exp_l_pat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        reset = 1'b1;
        // requests during reset must not be granted or write
        drv_c(1, 1, 8'h77, 8'h11);
        drv_l(1, 1, 8'h78, 8'h22, 1);
        to_neg();
        check("rst_lit_c_gnt", c_gnt, 0);
        check("rst_lit_wr_en", mem_wr_en, 0);
        to_pos(); to_pos();
        reset = 1'b0;
        drv_c(0, 0, 0, 0);
        drv_l(0, 0, 0, 0, 0);
        to_pos();

        // 1: core write then read back
        drv_c(1, 1, 8'h10, 8'hA5);
        to_neg(); check("t1_wr_gnt", c_gnt, 1); check("t1_wr_en", mem_wr_en, 1);
        to_pos();
        drv_c(1, 0, 8'h10, 8'h00);
        to_neg(); check("t1_rd_gnt", c_gnt, 1); check("t1_rd_wr_en", mem_wr_en, 0);
        to_pos();
        drv_c(0, 0, 0, 0);
        to_neg(); check("t1_rvalid", c_rvalid, 1); check("t1_rdata", c_rdata, 8'hA5);
        to_pos();

        // 2: contention, core wins, loader next
        drv_c(1, 0, 8'h01, 8'h00);
        drv_l(1, 1, 8'h02, 8'h3C, 0);
        to_neg(); check("t2_c_gnt", c_gnt, 1); check("t2_l_gnt", l_gnt, 0);
        to_pos();
        drv_c(0, 0, 0, 0);
        to_neg(); check("t2_l_gnt2", l_gnt, 1); check("t2_c_rdata", c_rdata, 8'h5B);
        to_pos();
        drv_l(0, 0, 0, 0, 0);
        to_neg(); check("t2_mem02", mem[8'h02], 8'h3C); check("t2_mem01", mem[8'h01], 8'h5B);
        to_pos();

        // 3: starvation under continuous core traffic
        c_pat = '0; l_pat = '0;
        for (int i = 0; i < 9; i++) begin
            drv_c(i < 8, 0, 8'h50, 8'h00);
            drv_l(1, 0, 8'h60, 8'h00, 0);
            to_neg();
            c_pat[i] = c_gnt; l_pat[i] = l_gnt;
            to_pos();
        end
        drv_c(0, 0, 0, 0);
        drv_l(0, 0, 0, 0, 0);
        exp_c_pat = STARVE_ON ? 9'b011101111 : 9'b011111111;
        exp_l_pat = STARVE_ON ? 9'b100010000 : 9'b100000000;
        check("t3_c_pattern", c_pat, exp_c_pat);
        check("t3_l_pattern", l_pat, exp_l_pat);
        to_pos();

        // 4: locked loader burst holds off the core
        for (int i = 0; i < 4; i++) begin
            drv_c(i > 0, 0, 8'h30, 8'h00);
            drv_l(1, 1, 8'(8'h20 + i), 8'(8'hC0 + i), i < 3);
            to_neg(); check("t4_l_gnt", l_gnt, 1); check("t4_c_gnt", c_gnt, 0);
            to_pos();
        end
        drv_l(0, 0, 0, 0, 0);
        to_neg(); check("t4_c_after", c_gnt, 1);
        to_pos();
        drv_c(0, 0, 0, 0);
        to_neg();
        check("t4_mem20", mem[8'h20], 8'hC0);
        check("t4_mem23", mem[8'h23], 8'hC3);
        to_pos();

        // 5: async reset in the middle of a locked read burst
        drv_l(1, 0, 8'h20, 8'h00, 1);
        to_neg(); check("t5_first_gnt", l_gnt, 1);
        to_pos();
        drv_c(1, 0, 8'h22, 8'h00);
        drv_l(1, 1, 8'h21, 8'hEE, 1);
        #1;
        check("t5_l_gnt_pre", l_gnt, 1);
        check("t5_l_rvalid_pre", l_rvalid, 1);
        check("t5_wr_en_pre", mem_wr_en, 1);
        reset = 1'b1;
        #1;
        check("t5_l_gnt_rst", l_gnt, 0);
        check("t5_l_rvalid_rst", l_rvalid, 0);
        check("t5_wr_en_rst", mem_wr_en, 0);
        to_neg();
        to_pos();
        reset = 1'b0;
        drv_c(1, 0, 8'h40, 8'h00);
        drv_l(1, 0, 8'h41, 8'h00, 0);
        to_neg(); check("t5_c_first", c_gnt, 1); check("t5_l_wait", l_gnt, 0);
        check("t5_mem21", mem[8'h21], 8'hC1);
        to_pos();
        drv_c(0, 0, 0, 0);
        to_neg(); check("t5_l_next", l_gnt, 1);
        to_pos();
        drv_l(0, 0, 0, 0, 0);

        // 6: loader request cancelled while core owns, then idle
        drv_c(1, 0, 8'h05, 8'h00);
        drv_l(1, 1, 8'h06, 8'h99, 0);
        to_neg(); check("t6_l_gnt", l_gnt, 0);
        to_pos();
        drv_l(0, 0, 0, 0, 0);
        to_neg(); check("t6_l_gnt2", l_gnt, 0);
        to_pos();
        drv_c(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check("t6_idle_wr_en", mem_wr_en, 0);
            check("t6_idle_l_rvalid", l_rvalid, 0);
            to_pos();
        end
        check("t6_mem06", mem[8'h06], 8'h5C);

        to_pos();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
